// File: rtl/vga_pkg.sv
// Shared VGA constants, colour type, palette and per-rectangle reset state.
// Pure definitions: no latency, no flow control.
package vga_pkg;

  localparam int COLOR_BITS = 3;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int POS_W      = 11;

  typedef struct packed {
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } rgb_t;

  // Every palette entry is full scale or off per channel, so a {r,g,b} mask is exact.
  function automatic logic [2:0] palette_mask(input int i);
    case (i)
      0:       return 3'b111;
      1:       return 3'b100;
      2:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic rgb_t palette(input int i);
    rgb_t       c;
    logic [2:0] m;
    m   = palette_mask(i);
    c.r = {COLOR_BITS{m[2]}};
    c.g = {COLOR_BITS{m[1]}};
    c.b = {COLOR_BITS{m[0]}};
    return c;
  endfunction

  function automatic logic [POS_W-1:0] rst_x(input int i);
    return POS_W'(50 + 80 * i);
  endfunction

  function automatic logic [POS_W-1:0] rst_y(input int i);
    return POS_W'(50 + 40 * i);
  endfunction

  // 1 = right/down; odd rectangles start heading left/up.
  function automatic logic rst_dir(input int i);
    return (i % 2) == 0;
  endfunction

endpackage

// File: rtl/vga_rect_mover.sv
// One rectangle: position/direction state with edge bounce, plus combinational hit test.
// Position steps on i_Update only; hit is same-cycle on col/row.
module vga_rect_mover
  import vga_pkg::*;
#(
  parameter int IDX         = 0,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int RECT_W      = 20,
  parameter int RECT_H      = 100,
  parameter int SPEED       = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Update,
  input  logic [9:0] i_Col_Count,
  input  logic [9:0] i_Row_Count,
  output logic       o_Hit
);

  localparam logic [POS_W-1:0] STEP  = POS_W'(SPEED);
  localparam logic [POS_W-1:0] W     = POS_W'(RECT_W);
  localparam logic [POS_W-1:0] H     = POS_W'(RECT_H);
  localparam logic [POS_W-1:0] COLS  = POS_W'(ACTIVE_COLS);
  localparam logic [POS_W-1:0] ROWS  = POS_W'(ACTIVE_ROWS);
  localparam logic [POS_W-1:0] MAX_X = POS_W'(ACTIVE_COLS - RECT_W);
  localparam logic [POS_W-1:0] MAX_Y = POS_W'(ACTIVE_ROWS - RECT_H);

  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             dx_q, dx_d, dy_q, dy_d;
  logic [POS_W-1:0] c, r;

  // Returns {next_pos, next_dir}; clamps to the edge and reverses instead of overshooting.
  function automatic logic [POS_W:0] step(input logic [POS_W-1:0] pos, input logic dir,
                                          input logic [POS_W-1:0] lim);
    logic [POS_W-1:0] nxt;
    if (dir) begin
      nxt = pos + STEP;
      if (nxt > lim) return {lim, 1'b0};
      return {nxt, 1'b1};
    end
    if (pos < STEP) return {POS_W'(0), 1'b1};
    return {pos - STEP, 1'b0};
  endfunction

  always_comb begin
    {x_d, dx_d} = {x_q, dx_q};
    {y_d, dy_d} = {y_q, dy_q};
    if (i_Update) begin
      {x_d, dx_d} = step(x_q, dx_q, MAX_X);
      {y_d, dy_d} = step(y_q, dy_q, MAX_Y);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      x_q  <= rst_x(IDX);
      y_q  <= rst_y(IDX);
      dx_q <= rst_dir(IDX);
      dy_q <= rst_dir(IDX);
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign c = {1'b0, i_Col_Count};
  assign r = {1'b0, i_Row_Count};

  assign o_Hit = (c >= x_q) && (c < x_q + W) && (r >= y_q) && (r < y_q + H) &&
                 (c < COLS) && (r < ROWS);

endmodule

// File: rtl/vga_rect_bouncer.sv
// Bouncing-rectangle pattern source; colour and tick registered 1 cycle after col/row, no backpressure.
// VGA_RECT_COLLIDE_EN adds overlap inversion and a per-frame o_Collision flag.
module vga_rect_bouncer
  import vga_pkg::*;
#(
  parameter int COLOR_BITS  = vga_pkg::COLOR_BITS,
  parameter int NUM_RECTS   = 2,
  parameter int ACTIVE_COLS = H_ACTIVE,
  parameter int ACTIVE_ROWS = V_ACTIVE,
  parameter int RECT_W      = 20,
  parameter int RECT_H      = 100,
  parameter int SPEED       = 1,
  parameter int FRAME_DIV   = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [9:0]            i_Col_Count,
  input  logic [9:0]            i_Row_Count,
  input  logic                  i_Enable,
  output logic [COLOR_BITS-1:0] o_Red_Video,
  output logic [COLOR_BITS-1:0] o_Grn_Video,
  output logic [COLOR_BITS-1:0] o_Blu_Video,
  output logic                  o_Frame_Tick,
  output logic                  o_Collision
);

  localparam int               DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  logic [DIV_W-1:0]      div_q, div_d;
  logic                  strobe, update, tick_q;
  logic [NUM_RECTS-1:0]  hit;
  logic [2:0]            win_m, pix_m;
  logic [COLOR_BITS-1:0] red_q, grn_q, blu_q;

  // First blanking line start: the whole visible frame has been scanned out.
  assign strobe = (i_Col_Count == 10'd0) && (i_Row_Count == 10'(ACTIVE_ROWS));
  assign update = strobe && i_Enable && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (strobe && i_Enable) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  for (genvar g = 0; g < NUM_RECTS; g++) begin : g_rect
    vga_rect_mover #(
      .IDX        (g),
      .ACTIVE_COLS(ACTIVE_COLS),
      .ACTIVE_ROWS(ACTIVE_ROWS),
      .RECT_W     (RECT_W),
      .RECT_H     (RECT_H),
      .SPEED      (SPEED)
    ) u_mover (
      .i_Clk      (i_Clk),
      .i_Rst_L    (i_Rst_L),
      .i_Update   (update),
      .i_Col_Count(i_Col_Count),
      .i_Row_Count(i_Row_Count),
      .o_Hit      (hit[g])
    );
  end

  // Descending scan so the lowest-index hit is written last and wins.
  always_comb begin
    win_m = 3'b000;
    for (int i = NUM_RECTS - 1; i >= 0; i--)
      if (hit[i]) win_m = palette_mask(i);
  end

`ifdef VGA_RECT_COLLIDE_EN
  logic multi, flag_q, coll_q;

  assign multi = (hit & (hit - NUM_RECTS'(1))) != '0;
  assign pix_m = multi ? ~win_m : win_m;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      flag_q <= 1'b0;
      coll_q <= 1'b0;
    end else if (strobe) begin
      coll_q <= flag_q;
      flag_q <= 1'b0;
    end else if (multi) begin
      flag_q <= 1'b1;
    end
  end

  assign o_Collision = coll_q;
`else
  assign pix_m       = win_m;
  assign o_Collision = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      red_q  <= '0;
      grn_q  <= '0;
      blu_q  <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= update;
      red_q  <= {COLOR_BITS{pix_m[2]}};
      grn_q  <= {COLOR_BITS{pix_m[1]}};
      blu_q  <= {COLOR_BITS{pix_m[0]}};
    end
  end

  assign o_Red_Video  = red_q;
  assign o_Grn_Video  = grn_q;
  assign o_Blu_Video  = blu_q;
  assign o_Frame_Tick = tick_q;

endmodule

// File: tb/tb_vga_rect_bouncer.sv
// Directed bench for vga_rect_bouncer: default build, edge clamp variant, and FRAME_DIV=4 variant.
module tb_vga_rect_bouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [9:0] col = '0;
  logic [9:0] row = '0;

  logic [2:0] ra, ga, ba, rb, gb, bb, rc, gc, bc;
  logic       ta, tb, tc, ca, cb, cc;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_a = 0;
  int tick_c = 0;

  localparam logic [8:0] WHT = 9'b111_111_111;
  localparam logic [8:0] RED = 9'b111_000_000;
  localparam logic [8:0] BLK = 9'b000_000_000;
`ifdef VGA_RECT_COLLIDE_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  typedef struct {
    int         c;
    int         r;
    logic [8:0] rgb;
  } vec_t;

  always #5 clk = ~clk;

  vga_rect_bouncer dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Col_Count(col), .i_Row_Count(row), .i_Enable(en),
    .o_Red_Video(ra), .o_Grn_Video(ga), .o_Blu_Video(ba), .o_Frame_Tick(ta), .o_Collision(ca)
  );

  vga_rect_bouncer #(.NUM_RECTS(1), .SPEED(2), .RECT_W(21)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Col_Count(col), .i_Row_Count(row), .i_Enable(en),
    .o_Red_Video(rb), .o_Grn_Video(gb), .o_Blu_Video(bb), .o_Frame_Tick(tb), .o_Collision(cb)
  );

  vga_rect_bouncer #(.NUM_RECTS(1), .FRAME_DIV(4)) dut_c (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Col_Count(col), .i_Row_Count(row), .i_Enable(en),
    .o_Red_Video(rc), .o_Grn_Video(gc), .o_Blu_Video(bc), .o_Frame_Tick(tc), .o_Collision(cc)
  );

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03o expected %03o", nm, act, exp);
    end
  endtask

  task automatic cyc(input int c, input int r);
    col = 10'(c);
    row = 10'(r);
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    cyc(0, 480);
    tick_a += int'(ta);
    tick_c += int'(tc);
    cyc(1, 480);
    tick_a += int'(ta);
    tick_c += int'(tc);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t vt[12];
    vt[0]  = '{50, 50, WHT};
    vt[1]  = '{49, 50, BLK};
    vt[2]  = '{70, 50, BLK};
    vt[3]  = '{69, 149, WHT};
    vt[4]  = '{69, 150, BLK};
    vt[5]  = '{50, 49, BLK};
    vt[6]  = '{130, 90, RED};
    vt[7]  = '{149, 189, RED};
    vt[8]  = '{150, 100, BLK};
    vt[9]  = '{129, 100, BLK};
    vt[10] = '{130, 190, BLK};
    vt[11] = '{60, 100, WHT};

    // Reset state with an in-rectangle pixel presented.
    col = 10'd50;
    row = 10'd50;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rgb_a", {ra, ga, ba}, BLK);
    chk("rst_rgb_b", {rb, gb, bb}, BLK);
    chk("rst_rgb_c", {rc, gc, bc}, BLK);
    chk("rst_tick_a", 9'(ta), 9'd0);
    chk("rst_tick_c", 9'(tc), 9'd0);
    chk("rst_coll_a", 9'(ca), 9'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].c, vt[i].r);
      chk($sformatf("vec%0d_rgb", i), {ra, ga, ba}, vt[i].rgb);
      chk($sformatf("vec%0d_tick", i), 9'(ta), 9'd0);
    end

    // One update: rect0 -> (51,51), rect1 -> (129,89).
    cyc(0, 480);
    chk("tick_on_strobe", 9'(ta), 9'd1);
    cyc(1, 480);
    chk("tick_one_cycle", 9'(ta), 9'd0);
    cyc(51, 51);   chk("r0_moved_in", {ra, ga, ba}, WHT);
    cyc(50, 51);   chk("r0_moved_left", {ra, ga, ba}, BLK);
    cyc(51, 50);   chk("r0_moved_top", {ra, ga, ba}, BLK);
    cyc(70, 120);  chk("r0_moved_right_in", {ra, ga, ba}, WHT);
    cyc(71, 120);  chk("r0_moved_right_out", {ra, ga, ba}, BLK);
    cyc(129, 89);  chk("r1_moved_in", {ra, ga, ba}, RED);
    cyc(128, 89);  chk("r1_moved_left", {ra, ga, ba}, BLK);
    cyc(129, 88);  chk("r1_moved_top", {ra, ga, ba}, BLK);
    cyc(148, 188); chk("r1_moved_corner", {ra, ga, ba}, RED);
    cyc(149, 188); chk("r1_moved_right_out", {ra, ga, ba}, BLK);

    // Motion disabled for three frames.
    en = 1'b0;
    tick_a = 0;
    repeat (3) strobe();
    chk("frozen_ticks", 9'(tick_a), 9'd0);
    cyc(51, 51);  chk("frozen_r0", {ra, ga, ba}, WHT);
    cyc(50, 51);  chk("frozen_r0_left", {ra, ga, ba}, BLK);
    cyc(129, 89); chk("frozen_r1", {ra, ga, ba}, RED);
    cyc(128, 89); chk("frozen_r1_left", {ra, ga, ba}, BLK);
    en = 1'b1;

    // Asynchronous reset mid-frame clears colour before any clock edge.
    cyc(60, 60);
    chk("pre_async_rst", {ra, ga, ba}, WHT);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", {ra, ga, ba}, BLK);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(50, 50);
    chk("rst_pos_a", {ra, ga, ba}, WHT);
    chk("rst_pos_c", {rc, gc, bc}, WHT);

    // FRAME_DIV=4: only the 4th strobe moves and ticks.
    tick_c = 0;
    for (int s = 1; s <= 3; s++) begin
      strobe();
      cyc(50, 50);
      chk($sformatf("div_hold_%0d", s), {rc, gc, bc}, WHT);
    end
    chk("div_no_tick", 9'(tick_c), 9'd0);
    strobe();
    cyc(50, 50); chk("div_moved_old", {rc, gc, bc}, BLK);
    cyc(51, 51); chk("div_moved_new", {rc, gc, bc}, WHT);
    chk("div_one_tick", 9'(tick_c), 9'd1);

    // Right-edge clamp with SPEED=2, limit 619: 618 -> 619 (flip) -> 617.
    reset_pulse();
    repeat (284) strobe();
    cyc(618, 144); chk("edge_x618", {rb, gb, bb}, WHT);
    cyc(617, 144); chk("edge_x618_left", {rb, gb, bb}, BLK);
    strobe();
    cyc(619, 142); chk("clamp_x619", {rb, gb, bb}, WHT);
    cyc(618, 142); chk("clamp_x619_left", {rb, gb, bb}, BLK);
    cyc(639, 142); chk("clamp_right_col", {rb, gb, bb}, WHT);
    strobe();
    cyc(617, 140); chk("bounce_x617", {rb, gb, bb}, WHT);
    cyc(637, 140); chk("bounce_right_in", {rb, gb, bb}, WHT);
    cyc(638, 140); chk("bounce_right_out", {rb, gb, bb}, BLK);
    cyc(617, 139); chk("bounce_y_top", {rb, gb, bb}, BLK);

    // Overlap after 31 updates: rect0 (81,81), rect1 (99,59).
    reset_pulse();
    repeat (31) strobe();
    chk("coll_before", 9'(ca), 9'd0);
    cyc(100, 100); chk("overlap_pix", {ra, ga, ba}, COLL ? BLK : WHT);
    cyc(101, 100); chk("r1_only_pix", {ra, ga, ba}, RED);
    cyc(0, 480);   chk("coll_after_strobe", 9'(ca), 9'(COLL));
    cyc(1, 480);
    cyc(0, 480);   chk("coll_clean_frame", 9'(ca), 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
